// File: rtl/spi_master_param.sv
// SPI master: parametrised word width, SCLK divider, CPOL/CPHA, bit order, multiple active-low selects.
// done pulses 1+H*(2*DATA_W+1) cycles after an accepted start; start is ignored while busy, abort returns to idle next cycle.
module spi_master_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CS = 2,
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              miso,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] sen_n
);
    localparam int unsigned      TOG_W    = $clog2(2 * DATA_W + 1);
    localparam logic [TOG_W-1:0] LAST_TOG = TOG_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [DIV_W:0]    r_cnt;
    logic [DIV_W-1:0]  r_div;
    logic [TOG_W-1:0]  r_tog;
    logic              r_cpol, r_cpha, r_lsb;
    logic [DATA_W-1:0] r_tx, r_rx;

    logic w_accept, w_bad, w_active, w_tick, w_edge, w_lead, w_last, w_sample, w_drive;

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_bad    = 32'(cs_sel) >= NUM_CS;
    assign w_active = (r_state == S_SETUP) || (r_state == S_XFER) || (r_state == S_HOLD);
    assign w_tick   = (r_cnt == {1'b0, r_div});
    assign w_edge   = w_tick && (r_state == S_SETUP || r_state == S_XFER);
    // r_tog counts toggles already made: an even count means the coming edge is a leading one
    assign w_lead   = ~r_tog[0];
    assign w_last   = w_edge && (r_tog == LAST_TOG);
    assign w_sample = w_edge && (w_lead ^ r_cpha);
    assign w_drive  = w_edge && (r_cpha ? w_lead : (!w_lead && !w_last));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = (w_accept && !w_bad) ? S_SETUP : S_IDLE;
            S_SETUP: if (abort) w_next = S_IDLE; else if (w_tick) w_next = S_XFER;
            S_XFER:  if (abort) w_next = S_IDLE; else if (w_last) w_next = S_HOLD;
            S_HOLD:  if (abort) w_next = S_IDLE; else if (w_tick) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rx_data <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            sen_n   <= '1;
            r_cnt   <= '0;
            r_div   <= '0;
            r_tog   <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_lsb   <= 1'b0;
            r_tx    <= '0;
            r_rx    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (w_accept) begin
                sclk <= cpol;
                if (w_bad) begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    sen_n <= '1;
                    mosi  <= 1'b0;
                end else begin
                    busy   <= 1'b1;
                    sen_n  <= ~(NUM_CS'(1) << cs_sel);
                    r_cpol <= cpol;
                    r_cpha <= cpha;
                    r_lsb  <= lsb_first;
                    r_div  <= clk_div;
                    r_cnt  <= '0;
                    r_tog  <= '0;
                    // cpha=0 presents the first bit before the first edge; cpha=1 drives it on that edge
                    mosi   <= cpha ? 1'b0 : first_bit(tx_data, lsb_first);
                    r_tx   <= cpha ? tx_data : shift_out(tx_data, lsb_first);
                end
            end else if (w_active && abort) begin
                busy  <= 1'b0;
                sen_n <= '1;
                mosi  <= 1'b0;
                sclk  <= r_cpol;
            end else if (!w_active) begin
                sclk <= cpol;
            end else begin
                r_cnt <= w_tick ? '0 : r_cnt + (DIV_W+1)'(1);
                if (w_edge) begin
                    sclk  <= ~sclk;
                    r_tog <= r_tog + TOG_W'(1);
                end
                if (w_sample) begin
                    r_rx <= r_lsb ? {miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], miso};
                end
                if (w_drive) begin
                    mosi <= first_bit(r_tx, r_lsb);
                    r_tx <= shift_out(r_tx, r_lsb);
                end
                if (r_state == S_HOLD && w_tick) begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    sen_n   <= '1;
                    mosi    <= 1'b0;
                    rx_data <= r_rx;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: scoreboard of expected done/err pulses against an SPI slave model.
// Three chip selects so that an out-of-range cs_sel is representable on the 2-bit select.
module tb_spi_master_param;
    localparam int DW  = 8;
    localparam int NCS = 3;

    logic       clk = 1'b0;
    logic       reset_n, start, abort, cpol, cpha, lsb_first, miso;
    logic [7:0] tx_data, clk_div, rx_data;
    logic [1:0] cs_sel;
    logic       busy, done, err, sclk, mosi;
    logic [2:0] sen_n;

    spi_master_param #(.DATA_W(DW), .NUM_CS(NCS), .DIV_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .tx_data(tx_data),
        .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
        .miso(miso), .busy(busy), .done(done), .err(err), .rx_data(rx_data), .sclk(sclk),
        .mosi(mosi), .sen_n(sen_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    typedef struct {
        bit         is_err;
        logic [7:0] rx;
        logic [7:0] tx;
        int         when;
    } exp_t;

    exp_t       sb[$];
    exp_t       me;
    logic [7:0] last_rx;

    // SPI slave: returns slv_word and captures what the master sends, per CPOL/CPHA rules
    logic [7:0] slv_word, slv_cap;
    logic       slv_miso;
    bit         loopback;
    int         slv_di, slv_si;

    assign miso = loopback ? mosi : slv_miso;

    function automatic logic bit_at(input logic [7:0] w, input int i, input logic lsb);
        return lsb ? w[i] : w[7-i];
    endfunction

    always @(sen_n) begin
        if (sen_n !== 3'b111) begin
            slv_di  = 0;
            slv_si  = 0;
            slv_cap = 8'h00;
            if (!cpha) begin
                slv_miso = bit_at(slv_word, 0, lsb_first);
                slv_di   = 1;
            end
        end
    end

    always @(sclk) begin
        if (reset_n && sen_n !== 3'b111) begin
            if ((sclk != cpol) ^ cpha) begin
                if (slv_si < 8) begin
                    slv_cap[lsb_first ? slv_si : 7 - slv_si] = mosi;
                    slv_si++;
                end
            end else if (slv_di < 8) begin
                slv_miso = bit_at(slv_word, slv_di, lsb_first);
                slv_di++;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && (done || err)) begin
            chk("done_err_excl", 32'(done && err), 0);
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(sb.size()), 1);
            end else begin
                me = sb.pop_front();
                chk("kind_err", 32'(err), 32'(me.is_err));
                chk("out_cycle", cyc, me.when);
                if (!me.is_err) begin
                    chk("rx_data", 32'(rx_data), 32'(me.rx));
                    chk("slave_rx", 32'(slv_cap), 32'(me.tx));
                end
            end
        end
    end

    task automatic run(input logic [7:0] tx, input logic [7:0] sw, input logic [1:0] cs,
                       input logic pol, input logic pha, input logic lsb,
                       input logic [7:0] div, input bit lb);
        int   t0, h, nexp, rel, ntog, nsen, ftog, ltog, n;
        logic prev;
        logic [2:0] mask;
        exp_t e;
        @(negedge clk);
        tx_data = tx; cs_sel = cs; cpol = pol; cpha = pha; lsb_first = lsb; clk_div = div;
        slv_word = sw; loopback = lb;
        @(negedge clk);
        start = 1'b1;
        abort = 1'($urandom_range(0, 1));
        t0    = cyc;
        h     = int'(div) + 1;
        nexp  = 1 + h * (2 * DW + 1);
        mask  = ~(3'b001 << cs);
        e.is_err = (int'(cs) >= NCS);
        e.tx     = tx;
        e.rx     = lb ? tx : sw;
        e.when   = e.is_err ? t0 + 1 : t0 + nexp;
        sb.push_back(e);
        if (!e.is_err) last_rx = e.rx;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        prev = pol; ntog = 0; nsen = 0; ftog = -1; ltog = -1; n = 0;
        while (!(done || err) && n < nexp + 8) begin
            rel = cyc - t0;
            if (sclk !== prev) begin
                ntog++;
                if (ftog < 0) ftog = rel;
                ltog = rel;
                prev = sclk;
            end
            if (sen_n === mask) nsen++;
            @(negedge clk);
            n++;
        end
        chk("complete", 32'(done || err), 1);
        if (e.is_err) begin
            chk("err_busy", 32'(busy), 0);
            chk("err_sen", 32'(sen_n), 7);
            chk("err_sclk", 32'(sclk), 32'(pol));
        end else begin
            chk("sclk_edges", ntog, 2 * DW);
            chk("first_edge", ftog, 1 + h);
            chk("last_edge", ltog, 1 + 2 * DW * h);
            chk("sen_cycles", nsen, nexp - 1);
            chk("done_sclk", 32'(sclk), 32'(pol));
            chk("done_sen", 32'(sen_n), 7);
            chk("done_busy", 32'(busy), 0);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_rx"}, 32'(rx_data), 0);
        chk({tag, "_sclk"}, 32'(sclk), 0);
        chk({tag, "_mosi"}, 32'(mosi), 0);
        chk({tag, "_sen"}, 32'(sen_n), 7);
    endtask

    initial begin
        int t0;
        reset_n = 1'b1; start = 1'b0; abort = 1'b0; tx_data = '0; cs_sel = '0;
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = '0;
        slv_word = '0; slv_miso = 1'b0; loopback = 1'b0; last_rx = '0;
        #1 reset_n = 1'b0;
        #2 check_reset("rst");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        run(8'hA5, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        run(8'h96, 8'h3C, 2'd0, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0);
        run(8'h5A, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

        // abort a mode-1 transfer at cycle 7
        @(negedge clk);
        tx_data = 8'hC3; cs_sel = 2'd2; cpol = 1'b0; cpha = 1'b1; lsb_first = 1'b0;
        clk_div = 8'd1; loopback = 1'b0; slv_word = 8'h77;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 7) @(negedge clk);
        chk("abort_pre_sclk", 32'(sclk), 1);
        chk("abort_pre_sen", 32'(sen_n), 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_sen", 32'(sen_n), 7);
        chk("abort_sclk", 32'(sclk), 0);
        chk("abort_rx", 32'(rx_data), 32'(last_rx));
        repeat (40) @(negedge clk);
        chk("abort_quiet_rx", 32'(rx_data), 32'(last_rx));

        // back-to-back: start held through DONE, abort raised in DONE too
        @(negedge clk);
        cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd0;
        loopback = 1'b1; tx_data = 8'h11;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        sb.push_back('{is_err: 1'b0, rx: 8'h11, tx: 8'h11, when: t0 + 18});
        sb.push_back('{is_err: 1'b0, rx: 8'h22, tx: 8'h22, when: t0 + 36});
        @(negedge clk);
        tx_data = 8'h22;
        while (cyc < t0 + 18) @(negedge clk);
        chk("b2b_done1", 32'(done), 1);
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("b2b_busy2", 32'(busy), 1);
        chk("b2b_sen2", 32'(sen_n), 6);
        while (cyc < t0 + 36) @(negedge clk);
        chk("b2b_done2", 32'(done), 1);
        last_rx = 8'h22;

        // asynchronous reset in the middle of a transfer
        @(negedge clk);
        cs_sel = 2'd0; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b1; clk_div = 8'd2;
        loopback = 1'b0; slv_word = 8'hE1; tx_data = 8'h4B;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        chk("arst_pre_busy", 32'(busy), 1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_reset("arst");
        last_rx = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run(8'h4B, 8'hE1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)), 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
